// File: rtl/legv8_pkg.sv
// legv8_pkg: widths and constants shared by the fetch unit and the core datapath
package legv8_pkg;
   localparam int INSTR_W = 32;
   localparam int ADDR_W = 64;
   localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular instruction buffer; entry i holds the word at head address + 4*i
module fetch_fifo
   import legv8_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [INSTR_W-1:0] wdata,
   output logic [INSTR_W-1:0] rdata,
   output logic [CW-1:0]      occ
);
   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [INSTR_W-1:0] mem_d [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] occ_q, occ_d;
   assign rdata = mem_q[head_q];
   assign occ = occ_q;
   // pointer and occupancy update; a write at a full buffer lands in the slot being popped
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[tail_q] = wdata;
      head_d = flush ? '0 : head_q + AW'(pop);
      tail_d = flush ? '0 : tail_q + AW'(push);
      occ_d = flush ? '0 : occ_q + CW'(push) - CW'(pop);
   end
   // buffer state, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         occ_q <= '0;
      end else begin
         mem_q <= mem_d;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q <= occ_d;
      end
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential prefetch front end for the LEGv8 core with redirect flush
module instr_fetch_unit
   import legv8_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               CLOCK,
   input  logic               RESET_N,
   input  logic [ADDR_W-1:0]  PC,
   input  logic               ADVANCE,
   output logic [INSTR_W-1:0] INSTRUCTION,
   output logic               INSTR_VALID,
   output logic               MISALIGNED,
   output logic               IMEM_REQ,
   output logic [ADDR_W-1:0]  IMEM_ADDR,
   input  logic               IMEM_GNT,
   input  logic               IMEM_RVALID,
   input  logic [INSTR_W-1:0] IMEM_RDATA
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
   logic [ADDR_W-1:0] exp_pc_q, exp_pc_d, fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] live_q, live_d, drop_q, drop_d, occ;
   logic [CW:0] pend, owed;
   logic redirect, xfer, dropping, push, pop;
   assign MISALIGNED = |PC[1:0];
   assign redirect = (PC != exp_pc_q) && !MISALIGNED;
   assign pend = {1'b0, occ} + {1'b0, live_q};
   assign owed = {1'b0, live_q} + {1'b0, drop_q};
   assign IMEM_REQ = RESET_N && !redirect && !MISALIGNED && (pend < LIM) && (owed < LIM);
   assign IMEM_ADDR = fetch_pc_q;
   assign xfer = IMEM_REQ && IMEM_GNT;
   assign dropping = IMEM_RVALID && (drop_q != '0);
   assign push = IMEM_RVALID && (drop_q == '0) && !redirect;
   assign INSTR_VALID = (occ != '0) && !redirect && !MISALIGNED;
   assign pop = ADVANCE && INSTR_VALID;
   // stream addresses and credit counters; on redirect every owed response becomes stale
   always_comb begin
      exp_pc_d = redirect ? PC : pop ? exp_pc_q + PC_STEP : exp_pc_q;
      fetch_pc_d = redirect ? PC : xfer ? fetch_pc_q + PC_STEP : fetch_pc_q;
      live_d = redirect ? '0 : live_q + CW'(xfer) - CW'(push);
      drop_d = redirect ? drop_q + live_q - CW'(IMEM_RVALID) : drop_q - CW'(dropping);
   end
   // fetch state registers
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         exp_pc_q <= '0;
         fetch_pc_q <= '0;
         live_q <= '0;
         drop_q <= '0;
      end else begin
         exp_pc_q <= exp_pc_d;
         fetch_pc_q <= fetch_pc_d;
         live_q <= live_d;
         drop_q <= drop_d;
      end
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (CLOCK),
      .rst_n (RESET_N),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata (IMEM_RDATA),
      .rdata (INSTRUCTION),
      .occ   (occ)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios against an in-order variable-latency memory model
module tb_instr_fetch_unit;
   logic CLOCK = 0, RESET_N = 1, ADVANCE = 0, IMEM_GNT = 1, IMEM_RVALID = 0;
   logic [63:0] PC = 0;
   logic [31:0] IMEM_RDATA = 0;
   logic [31:0] INSTRUCTION;
   logic INSTR_VALID, MISALIGNED, IMEM_REQ;
   logic [63:0] IMEM_ADDR;
   int checks = 0, errors = 0, cyc = 0, lat = 1;
   logic [63:0] pend_a[$];
   int pend_t[$];
   logic [63:0] glog[$];

   always #5 CLOCK = ~CLOCK;

   instr_fetch_unit #(.DEPTH(4)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .PC(PC), .ADVANCE(ADVANCE),
      .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID), .MISALIGNED(MISALIGNED),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
      .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA)
   );

   function automatic logic [31:0] mem(input logic [63:0] a);
      return a[31:0] ^ 32'h8B00_0000 ^ {a[15:0], 16'h0};
   endfunction

   // one clock cycle: record handshakes, advance the memory model
   task automatic tick();
      if (IMEM_REQ && IMEM_GNT) begin
         pend_a.push_back(IMEM_ADDR);
         pend_t.push_back(cyc + lat);
         glog.push_back(IMEM_ADDR);
      end
      if (IMEM_RVALID) begin
         void'(pend_a.pop_front());
         void'(pend_t.pop_front());
      end
      @(posedge CLOCK);
      #1;
      cyc++;
      IMEM_RVALID = 0;
      IMEM_RDATA = 0;
      if (pend_a.size() > 0) begin
         if (pend_t[0] <= cyc) begin
            IMEM_RVALID = 1;
            IMEM_RDATA = mem(pend_a[0]);
         end
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!INSTR_VALID && n < 20) begin
         tick();
         #1;
         n++;
      end
   endtask

   task automatic do_reset();
      RESET_N = 0;
      IMEM_RVALID = 0;
      IMEM_RDATA = 0;
      pend_a.delete();
      pend_t.delete();
      glog.delete();
      PC = 0;
      ADVANCE = 0;
      IMEM_GNT = 1;
      repeat (2) @(posedge CLOCK);
      #1;
      RESET_N = 1;
      cyc = 0;
   endtask

   task automatic test_reset();
      #1 RESET_N = 0;
      #1;
      checks += 5;
      if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", IMEM_REQ); end
      if (IMEM_ADDR !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", IMEM_ADDR); end
      if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", INSTR_VALID); end
      if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", INSTRUCTION); end
      if (MISALIGNED !== 1'b0) begin errors++; $display("FAIL reset_mis0 got %b want 0", MISALIGNED); end
      PC = 64'h3;
      #1;
      checks++;
      if (MISALIGNED !== 1'b1) begin errors++; $display("FAIL reset_mis1 got %b want 1", MISALIGNED); end
      PC = 0;
   endtask

   task automatic test_fill();
      logic er[6] = '{1, 1, 1, 1, 0, 0};
      logic ev[6] = '{0, 0, 1, 1, 1, 1};
      logic [63:0] ea[4] = '{64'h0, 64'h4, 64'h8, 64'hC};
      do_reset();
      lat = 1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks += 2;
         if (IMEM_REQ !== er[i]) begin errors++; $display("FAIL fill_req[%0d] got %b want %b", i, IMEM_REQ, er[i]); end
         if (INSTR_VALID !== ev[i]) begin errors++; $display("FAIL fill_valid[%0d] got %b want %b", i, INSTR_VALID, ev[i]); end
         if (i < 4) begin
            checks++;
            if (IMEM_ADDR !== ea[i]) begin errors++; $display("FAIL fill_addr[%0d] got %h want %h", i, IMEM_ADDR, ea[i]); end
         end
         if (ev[i]) begin
            checks++;
            if (INSTRUCTION !== mem(0)) begin errors++; $display("FAIL fill_instr[%0d] got %h want %h", i, INSTRUCTION, mem(0)); end
         end
         tick();
      end
   endtask

   task automatic test_streaming();
      logic adv;
      ADVANCE = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks += 2;
         if (INSTR_VALID !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, INSTR_VALID); end
         if (INSTRUCTION !== mem(PC)) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, INSTRUCTION, mem(PC)); end
         adv = INSTR_VALID;
         tick();
         if (adv) PC += 4;
      end
      ADVANCE = 0;
   endtask

   task automatic test_redirect();
      int n;
      do_reset();
      lat = 3;
      repeat (3) begin
         #1;
         tick();
      end
      PC = 64'h40;
      #1;
      checks += 2;
      if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL redir_req got %b want 0", IMEM_REQ); end
      if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", INSTR_VALID); end
      tick();
      #1;
      checks += 2;
      if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL redir_req1 got %b want 1", IMEM_REQ); end
      if (IMEM_ADDR !== 64'h40) begin errors++; $display("FAIL redir_addr got %h want 40", IMEM_ADDR); end
      wait_valid(n);
      checks++;
      if (n !== 4) begin errors++; $display("FAIL redir_latency got %0d want 4", n); end
      for (int k = 0; k < 3; k++) begin
         wait_valid(n);
         checks++;
         if (!INSTR_VALID || INSTRUCTION !== mem(PC)) begin
            errors++;
            $display("FAIL redir_instr[%0d] got %h/%b want %h/1", k, INSTRUCTION, INSTR_VALID, mem(PC));
         end
         ADVANCE = 1;
         tick();
         ADVANCE = 0;
         PC += 4;
      end
   endtask

   task automatic test_backpressure();
      logic adv;
      do_reset();
      lat = 1;
      IMEM_GNT = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks += 2;
         if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL bp_req[%0d] got %b want 1", i, IMEM_REQ); end
         if (IMEM_ADDR !== 64'h0) begin errors++; $display("FAIL bp_addr[%0d] got %h want 0", i, IMEM_ADDR); end
         tick();
      end
      checks++;
      if (glog.size() != 0) begin errors++; $display("FAIL bp_nogrant got %0d want 0", glog.size()); end
      IMEM_GNT = 1;
      ADVANCE = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (INSTR_VALID) begin
            checks++;
            if (INSTRUCTION !== mem(PC)) begin errors++; $display("FAIL bp_instr[%0d] got %h want %h", i, INSTRUCTION, mem(PC)); end
         end
         adv = INSTR_VALID;
         tick();
         if (adv) PC += 4;
      end
      ADVANCE = 0;
      checks++;
      if (glog.size() < 8) begin errors++; $display("FAIL bp_count got %0d want >=8", glog.size()); end
      for (int i = 0; i < glog.size(); i++) begin
         checks++;
         if (glog[i] !== 64'(4 * i)) begin errors++; $display("FAIL bp_seq[%0d] got %h want %h", i, glog[i], 64'(4 * i)); end
      end
   endtask

   task automatic test_misaligned();
      int n;
      PC = 64'h42;
      ADVANCE = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks += 3;
         if (MISALIGNED !== 1'b1) begin errors++; $display("FAIL mis_flag[%0d] got %b want 1", i, MISALIGNED); end
         if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL mis_req[%0d] got %b want 0", i, IMEM_REQ); end
         if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL mis_valid[%0d] got %b want 0", i, INSTR_VALID); end
         tick();
      end
      ADVANCE = 0;
      PC = 64'h40;
      #1;
      checks += 2;
      if (MISALIGNED !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", MISALIGNED); end
      if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL mis_redir_req got %b want 0", IMEM_REQ); end
      tick();
      #1;
      checks++;
      if (IMEM_ADDR !== 64'h40) begin errors++; $display("FAIL mis_refetch got %h want 40", IMEM_ADDR); end
      wait_valid(n);
      checks++;
      if (!INSTR_VALID || INSTRUCTION !== mem(64'h40)) begin
         errors++;
         $display("FAIL mis_recover got %h/%b want %h/1", INSTRUCTION, INSTR_VALID, mem(64'h40));
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      lat = 3;
      repeat (6) begin
         #1;
         tick();
      end
      #1;
      checks++;
      if (INSTR_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", INSTR_VALID); end
      #1 RESET_N = 0;
      #1;
      checks += 4;
      if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", INSTR_VALID); end
      if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", IMEM_REQ); end
      if (IMEM_ADDR !== 64'h0) begin errors++; $display("FAIL mid_addr got %h want 0", IMEM_ADDR); end
      if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL mid_instr got %h want 0", INSTRUCTION); end
      do_reset();
      #1;
      checks += 2;
      if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL mid_restart_req got %b want 1", IMEM_REQ); end
      if (IMEM_ADDR !== 64'h0) begin errors++; $display("FAIL mid_restart_addr got %h want 0", IMEM_ADDR); end
      tick();
      #1;
      checks++;
      if (IMEM_ADDR !== 64'h4) begin errors++; $display("FAIL mid_restart_addr1 got %h want 4", IMEM_ADDR); end
      wait_valid(n);
      checks++;
      if (!INSTR_VALID || INSTRUCTION !== mem(0)) begin
         errors++;
         $display("FAIL mid_restart_instr got %h/%b want %h/1", INSTRUCTION, INSTR_VALID, mem(0));
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_streaming();
      test_redirect();
      test_backpressure();
      test_misaligned();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
